// File: rtl/picorv32_mem_protocol_monitor.sv
// Passive PicoRV32 native memory bus checker.
// Sticky protocol errors, first-error record, traffic and latency counters.
module picorv32_mem_protocol_monitor #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT     = 50,
  parameter int CNT_W       = 16,
  parameter int CHECK_WDATA = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                mem_valid,
  input  logic                mem_instr,
  input  logic                mem_ready,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                err_clr,
  output logic [9:0]          err_flags,
  output logic                err_irq,
  output logic [3:0]          first_err_code,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [CNT_W-1:0]    ifetch_cnt,
  output logic [CNT_W-1:0]    load_cnt,
  output logic [CNT_W-1:0]    store_cnt,
  output logic [CNT_W-1:0]    max_lat
);

  localparam int SW = DATA_W / 8;
  localparam int AL = $clog2(SW);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic {IDLE, PEND} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  lat, lat_n, lat_inc, done_lat;
  logic              snap_en, done;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [SW-1:0]     s_wstrb;
  logic              s_instr;
  logic [9:0]        errs, flags_n;
  logic [3:0]        code_n;
  logic              rec, pend, pend_v;

  function automatic logic strb_legal(input logic [SW-1:0] s);
    logic          ok;
    logic [SW-1:0] m;
    ok = 1'b0;
    for (int k = 0; k <= AL; k++) begin
      for (int p = 0; p < SW; p += (1 << k)) begin
        m = SW'(((64'd1 << (1 << k)) - 64'd1) << p);
        if (s == m) ok = 1'b1;
      end
    end
    return ok;
  endfunction

  function automatic logic [CNT_W-1:0] sinc(input logic [CNT_W-1:0] c);
    return (c == CMAX) ? c : c + ONE;
  endfunction

  assign lat_inc = sinc(lat);
  assign pend    = (state == PEND);
  assign pend_v  = pend & mem_valid;

  always_comb begin
    state_n  = state;
    lat_n    = lat;
    snap_en  = 1'b0;
    done     = 1'b0;
    done_lat = lat_inc;
    unique case (state)
      IDLE: begin
        if (mem_valid && mem_ready) begin
          done     = 1'b1;
          done_lat = ONE;
        end else if (mem_valid) begin
          state_n = PEND;
          snap_en = 1'b1;
          lat_n   = ONE;
        end
      end
      PEND: begin
        lat_n = lat_inc;
        if (!mem_valid) begin
          state_n = IDLE;
        end else if (mem_ready) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    errs    = '0;
    errs[0] = mem_ready & ~mem_valid;
    errs[1] = pend & ~mem_valid;
    errs[2] = pend_v & (mem_addr != s_addr);
    errs[3] = pend_v & (mem_wstrb != s_wstrb);
    errs[4] = pend_v & (mem_instr != s_instr);
    errs[5] = (CHECK_WDATA != 0) & pend_v & (|s_wstrb)
            & (mem_wdata != s_wdata);
    errs[6] = mem_valid & (|mem_addr[AL-1:0]);
    errs[7] = mem_valid & (|mem_wstrb) & ~strb_legal(mem_wstrb);
    errs[8] = mem_valid & mem_instr & (|mem_wstrb);
    // lat passes TIMEOUT once, so this fires once per transaction
    errs[9] = pend & (lat == TMO) & ~mem_ready;
  end

  always_comb begin
    code_n = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (errs[i]) code_n = 4'(i);
    end
    flags_n = (err_clr ? 10'd0 : err_flags) | errs;
    rec     = (|errs) & (err_clr | ~(|err_flags));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      lat     <= '0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
      s_instr <= 1'b0;
    end else begin
      state <= state_n;
      lat   <= lat_n;
      if (snap_en) begin
        s_addr  <= mem_addr;
        s_wdata <= mem_wdata;
        s_wstrb <= mem_wstrb;
        s_instr <= mem_instr;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_flags      <= '0;
      err_irq        <= 1'b0;
      first_err_code <= '0;
      first_err_addr <= '0;
    end else begin
      err_flags <= flags_n;
      err_irq   <= |flags_n;
      if (rec) begin
        first_err_code <= code_n;
        first_err_addr <= mem_addr;
      end else if (err_clr) begin
        first_err_code <= '0;
        first_err_addr <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ifetch_cnt <= '0;
      load_cnt   <= '0;
      store_cnt  <= '0;
      max_lat    <= '0;
    end else if (done) begin
      if (mem_instr) ifetch_cnt <= sinc(ifetch_cnt);
      else if (mem_wstrb == '0) load_cnt <= sinc(load_cnt);
      else store_cnt <= sinc(store_cnt);
      if (done_lat > max_lat) max_lat <= done_lat;
    end
  end

endmodule

// File: tb/tb_picorv32_mem_protocol_monitor.sv
// Directed bench for picorv32_mem_protocol_monitor.
// Transaction-level model checked every cycle, plus literal scenario checks.
module tb_picorv32_mem_protocol_monitor;

  localparam int TMO = 5;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0, mem_instr = 1'b0, mem_ready = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        err_clr = 1'b0;
  logic [9:0]  err_flags;
  logic        err_irq;
  logic [3:0]  first_err_code;
  logic [31:0] first_err_addr;
  logic [15:0] ifetch_cnt, load_cnt, store_cnt, max_lat;

  picorv32_mem_protocol_monitor #(
    .DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO), .CNT_W(16), .CHECK_WDATA(1)
  ) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .err_clr(err_clr), .err_flags(err_flags), .err_irq(err_irq),
    .first_err_code(first_err_code), .first_err_addr(first_err_addr),
    .ifetch_cnt(ifetch_cnt), .load_cnt(load_cnt), .store_cnt(store_cnt),
    .max_lat(max_lat)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endtask

  // model state: transaction view, not an FSM encoding
  bit          m_act, m_to;
  int          m_n;
  logic [31:0] m_addr, m_wd;
  logic [3:0]  m_ws;
  bit          m_instr;
  int          m_if, m_ld, m_st, m_max;
  logic [9:0]  m_flags;
  int          m_code;
  logic [31:0] m_faddr;

  function automatic bit legal(input logic [3:0] s);
    int n, lo;
    logic [3:0] m;
    n = $countones(s);
    lo = 0;
    for (int i = 3; i >= 0; i--) if (s[i]) lo = i;
    m = 4'(((1 << n) - 1) << lo);
    return (n == 1 || n == 2 || n == 4) && (lo % n == 0) && (s == m);
  endfunction

  always @(posedge clk or negedge resetn) begin
    logic [9:0] e;
    int lt;
    if (!resetn) begin
      m_act = 0; m_to = 0; m_n = 0;
      m_if = 0; m_ld = 0; m_st = 0; m_max = 0;
      m_flags = '0; m_code = 0; m_faddr = '0;
    end else begin
      e = '0;
      if (mem_ready && !mem_valid) e[0] = 1;
      if (m_act && !mem_valid) e[1] = 1;
      if (m_act && mem_valid) begin
        if (mem_addr != m_addr) e[2] = 1;
        if (mem_wstrb != m_ws) e[3] = 1;
        if (mem_instr != m_instr) e[4] = 1;
        if (m_ws != 0 && mem_wdata != m_wd) e[5] = 1;
      end
      if (mem_valid && (mem_addr % 4) != 0) e[6] = 1;
      if (mem_valid && mem_wstrb != 0 && !legal(mem_wstrb)) e[7] = 1;
      if (mem_valid && mem_instr && mem_wstrb != 0) e[8] = 1;
      if (m_act && m_n == TMO && !mem_ready && !m_to) begin
        e[9] = 1;
        m_to = 1;
      end
      if (e != 0 && (err_clr || m_flags == 0)) begin
        m_code = 0;
        for (int i = 9; i >= 0; i--) if (e[i]) m_code = i;
        m_faddr = mem_addr;
      end else if (err_clr) begin
        m_code = 0;
        m_faddr = '0;
      end
      if (err_clr) m_flags = '0;
      m_flags |= e;
      if (mem_valid && mem_ready) begin
        lt = m_act ? m_n + 1 : 1;
        if (mem_instr) m_if++;
        else if (mem_wstrb == 0) m_ld++;
        else m_st++;
        if (lt > m_max) m_max = lt;
        m_act = 0;
      end else if (m_act && !mem_valid) begin
        m_act = 0;
      end else if (m_act) begin
        m_n++;
      end else if (mem_valid) begin
        m_act = 1; m_to = 0; m_n = 1;
        m_addr = mem_addr; m_wd = mem_wdata;
        m_ws = mem_wstrb; m_instr = mem_instr;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_on && resetn) begin
      chk("flags", err_flags, m_flags);
      chk("irq", err_irq, m_flags != 0);
      chk("code", first_err_code, m_code);
      chk("faddr", first_err_addr, m_faddr);
      chk("ifetch", ifetch_cnt, m_if);
      chk("load", load_cnt, m_ld);
      chk("store", store_cnt, m_st);
      chk("maxlat", max_lat, m_max);
    end
  end

  task automatic drive(input bit v, input bit i, input bit r,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input bit c);
    mem_valid = v; mem_instr = i; mem_ready = r;
    mem_addr = a; mem_wdata = wd; mem_wstrb = ws; err_clr = c;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 0);
  endtask

  task automatic clr();
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 1);
  endtask

  task automatic all_zero(input string n);
    chk({n, "_flags"}, err_flags, 0);
    chk({n, "_irq"}, err_irq, 0);
    chk({n, "_code"}, first_err_code, 0);
    chk({n, "_faddr"}, first_err_addr, 0);
    chk({n, "_if"}, ifetch_cnt, 0);
    chk({n, "_ld"}, load_cnt, 0);
    chk({n, "_st"}, store_cnt, 0);
    chk({n, "_max"}, max_lat, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    all_zero("reset");
    resetn = 1'b1;
    chk_on = 1;

    // legal traffic
    drive(1, 1, 0, 32'h100, 0, 4'h0, 0);
    drive(1, 1, 0, 32'h100, 0, 4'h0, 0);
    drive(1, 1, 1, 32'h100, 0, 4'h0, 0);
    idle();
    drive(1, 0, 1, 32'h200, 0, 4'h0, 0);
    drive(1, 0, 0, 32'h300, 32'h12345678, 4'hF, 0);
    drive(1, 0, 1, 32'h300, 32'h12345678, 4'hF, 0);
    idle();
    chk("legal_flags", err_flags, 0);
    chk("legal_if", ifetch_cnt, 1);
    chk("legal_ld", load_cnt, 1);
    chk("legal_st", store_cnt, 1);
    chk("legal_max", max_lat, 3);

    // write-data stability
    drive(1, 0, 0, 32'h40, 32'hDEADBEEF, 4'hF, 0);
    drive(1, 0, 0, 32'h40, 32'hDEADBEEE, 4'hF, 0);
    drive(1, 0, 0, 32'h40, 32'hDEADBEEE, 4'hF, 0);
    drive(1, 0, 1, 32'h40, 32'hDEADBEEE, 4'hF, 0);
    idle();
    chk("e5_flags", err_flags, 10'h020);
    chk("e5_code", first_err_code, 5);
    chk("e5_addr", first_err_addr, 32'h40);
    chk("e5_irq", err_irq, 1);
    chk("e5_st", store_cnt, 2);
    clr();
    chk("clr_flags", err_flags, 0);

    // protocol misuse
    drive(0, 0, 1, 32'h0, 0, 4'h0, 0);
    chk("e0_flags", err_flags, 10'h001);
    chk("e0_code", first_err_code, 0);
    drive(1, 0, 0, 32'h80, 0, 4'h0, 0);
    drive(0, 0, 0, 32'h80, 0, 4'h0, 1);
    chk("e1_flags", err_flags, 10'h002);
    chk("e1_code", first_err_code, 1);
    chk("e1_addr", first_err_addr, 32'h80);
    clr();

    // strobes and alignment
    drive(1, 0, 1, 32'h10, 32'h1, 4'b0110, 0);
    chk("e7_flags", err_flags, 10'h080);
    chk("e7_code", first_err_code, 7);
    clr();
    drive(1, 0, 1, 32'h14, 32'h2, 4'b1100, 0);
    chk("hi_half", err_flags, 0);
    drive(1, 1, 1, 32'h18, 32'h0, 4'b0001, 0);
    chk("e8_flags", err_flags, 10'h100);
    chk("e8_code", first_err_code, 8);
    clr();
    drive(1, 0, 1, 32'h102, 0, 4'h0, 0);
    chk("e6_flags", err_flags, 10'h040);
    chk("e6_code", first_err_code, 6);
    clr();
    drive(1, 1, 1, 32'h103, 0, 4'b0110, 0);
    chk("multi_flags", err_flags, 10'h1C0);
    chk("multi_code", first_err_code, 6);
    chk("multi_addr", first_err_addr, 32'h103);
    clr();

    // timeout: 8 cycles without ready, ready on the 9th
    repeat (7) drive(1, 0, 0, 32'h500, 0, 4'h0, 0);
    chk("e9_flags", err_flags, 10'h200);
    chk("e9_code", first_err_code, 9);
    drive(1, 0, 0, 32'h500, 0, 4'h0, 1);
    drive(1, 0, 1, 32'h500, 0, 4'h0, 0);
    idle();
    chk("e9_once", err_flags, 0);
    chk("to_max", max_lat, 9);
    chk("to_ld", load_cnt, 3);

    // error left set, then asynchronous reset inside a pending load
    drive(0, 0, 1, 32'h0, 0, 4'h0, 0);
    drive(1, 0, 0, 32'h600, 0, 4'h0, 0);
    drive(1, 0, 0, 32'h600, 0, 4'h0, 0);
    #2 resetn = 1'b0;
    #1 all_zero("async");
    @(negedge clk);
    resetn = 1'b1;
    drive(1, 0, 0, 32'h600, 0, 4'h0, 0);
    drive(1, 0, 1, 32'h600, 0, 4'h0, 0);
    idle();
    chk("rst_flags", err_flags, 0);
    chk("rst_ld", load_cnt, 1);
    chk("rst_max", max_lat, 2);

    idle();
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
